// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial write_in/data_in bit link.
// The transmitter (serializador) and the receiver (deserializador) both
// import this package, so their word-width constant always matches.
//   ser_state_t        transmitter FSM states
//   SER_DEFAULT_WIDTH  default word width of the link
package serial_link_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RX,
    STROBE,
    GAP
  } ser_state_t;

  localparam int SER_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serializador_shreg.sv
// Loadable MSB-first shift register with a remaining-bit counter.
// Ports:
//   clk_100KHz  system clock, rising edge
//   reset       asynchronous active-low reset; clears the register and counter
//   load        latch din and set the counter to DATA_WIDTH (has priority)
//   shift       drop the current MSB and decrement the counter
//   din         parallel word to load
//   msb         bit currently presented for transmission
//   empty       high when every loaded bit has been shifted out
module serializador_shreg
  import serial_link_pkg::*;
#(
  parameter int DATA_WIDTH = SER_DEFAULT_WIDTH
) (
  input  logic                  clk_100KHz,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  msb,
  output logic                  empty
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         bit_cnt;

  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      shreg   <= din;
      bit_cnt <= CW'(DATA_WIDTH);
    end else if (shift && (bit_cnt != '0)) begin
      // The counter saturates at zero, so a stray shift never wraps it.
      shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
      bit_cnt <= bit_cnt - CW'(1);
    end
  end

  assign msb   = shreg[DATA_WIDTH-1];
  assign empty = (bit_cnt == '0);

endmodule

// File: rtl/serializador.sv
// Parallel-to-serial transmitter: the sending end of the write_in/data_in
// bit link consumed by the deserializador. A word is taken through a
// valid/ready handshake and shifted out MSB-first, one bit per write strobe,
// with GAP_CYCLES low cycles after each strobe. The start of a word is held
// off while the receiver reports busy on status_in.
// Optional feature: define SERIALIZADOR_BUF_EN to add a one-word holding
// buffer so the next word can be accepted while the current one is shifting.
// Ports:
//   clk_100KHz  system clock, rising edge
//   reset       asynchronous assert, active-low; synchronous release
//   data_in     parallel word to transmit
//   valid_in    data_in is valid; transfer when valid_in && ready_out
//   status_in   receiver busy; 1 = do not start a word
//   ready_out   a word can be accepted this cycle
//   data_out    serial bit to the receiver's data_in
//   write_out   one-cycle strobe marking data_out valid
//   busy_out    a word is being shifted or is waiting for status_in
module serializador
  import serial_link_pkg::*;
#(
  parameter int DATA_WIDTH = SER_DEFAULT_WIDTH,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  clk_100KHz,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  input  logic                  status_in,
  output logic                  ready_out,
  output logic                  data_out,
  output logic                  write_out,
  output logic                  busy_out
);

  localparam int            GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  ser_state_t            state;
  ser_state_t            next_state;
  logic [GW-1:0]         gap_cnt;
  logic                  gap_last;
  logic                  word_end;
  logic                  accept;
  logic                  load;
  logic                  shift;
  logic                  msb;
  logic                  empty;
  logic [DATA_WIDTH-1:0] load_word;

  assign gap_last = (gap_cnt == GAP_LAST);
  // Last gap cycle of the last bit: the only point where a new word may follow.
  assign word_end = (state == GAP) && gap_last && empty;
  assign accept   = valid_in && ready_out;
  assign shift    = (state == STROBE);
  assign busy_out = (state != IDLE);

`ifdef SERIALIZADOR_BUF_EN
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] buf_word;
  logic                  drain;
  logic                  direct;

  assign ready_out = !buf_full;
  assign drain     = word_end && buf_full;
  // An accepted word bypasses the buffer when the shift register can take it now.
  assign direct    = accept && ((state == IDLE) || (word_end && !buf_full));
  assign load      = direct || drain;
  // The buffered word is older than anything on data_in, so it goes first.
  assign load_word = drain ? buf_word : data_in;

  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      buf_full <= 1'b0;
    end else if (accept && !direct) begin
      buf_full <= 1'b1;
    end else if (drain) begin
      buf_full <= 1'b0;
    end
  end

  always_ff @(posedge clk_100KHz) begin
    if (accept && !direct) begin
      buf_word <= data_in;
    end
  end
`else
  assign ready_out = (state == IDLE) || word_end;
  assign load      = accept;
  assign load_word = data_in;
`endif

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (load) next_state = status_in ? WAIT_RX : STROBE;
      end
      WAIT_RX: begin
        if (!status_in) next_state = STROBE;
      end
      STROBE: begin
        next_state = GAP;
      end
      GAP: begin
        if (gap_last) begin
          if (!empty)    next_state = STROBE;
          else if (load) next_state = status_in ? WAIT_RX : STROBE;
          else           next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_100KHz or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      write_out <= 1'b0;
      data_out  <= 1'b0;
      gap_cnt   <= '0;
    end else begin
      state     <= next_state;
      write_out <= (next_state == STROBE);
      // On a word start the register is loading this very edge, so the
      // first bit comes straight from the incoming word.
      if (next_state == STROBE) begin
        data_out <= load ? load_word[DATA_WIDTH-1] : msb;
      end
      gap_cnt   <= ((state == GAP) && !gap_last) ? gap_cnt + GW'(1) : '0;
    end
  end

  serializador_shreg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_shreg (
    .clk_100KHz (clk_100KHz),
    .reset      (reset),
    .load       (load),
    .shift      (shift),
    .din        (load_word),
    .msb        (msb),
    .empty      (empty)
  );

endmodule

// File: tb/tb_serializador.sv
// Testbench for serializador: randomized words checked against a bit-level
// reference of the link (MSB-first bits, strobe spacing, start latency).
module tb_serializador;

  localparam int W    = 8;
  localparam int G    = 1;
  localparam int STEP = 1 + G;

  logic         clk_100KHz = 1'b0;
  logic         reset      = 1'b0;
  logic [W-1:0] data_in    = '0;
  logic         valid_in   = 1'b0;
  logic         status_in  = 1'b0;
  logic         ready_out;
  logic         data_out;
  logic         write_out;
  logic         busy_out;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int strb_cyc[$];
  bit strb_bit[$];
  bit exp_bit[$];

  serializador #(
    .DATA_WIDTH (W),
    .GAP_CYCLES (G)
  ) dut (
    .clk_100KHz (clk_100KHz),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .status_in  (status_in),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .write_out  (write_out),
    .busy_out   (busy_out)
  );

  always #5 clk_100KHz = ~clk_100KHz;

  always @(posedge clk_100KHz) cyc <= cyc + 1;

  // Link monitor: what a receiver on write_in/data_in would capture.
  always @(negedge clk_100KHz) begin
    if (write_out === 1'b1) begin
      strb_cyc.push_back(cyc);
      strb_bit.push_back(data_out);
    end
  end

  task automatic tick();
    @(posedge clk_100KHz);
    #1;
  endtask

  task automatic clear_mon();
    strb_cyc.delete();
    strb_bit.delete();
    exp_bit.delete();
  endtask

  // Reference: a word travels as its bits from the most significant down.
  task automatic model_word(input logic [W-1:0] w);
    int unsigned v;
    v = w;
    for (int i = W - 1; i >= 0; i--) exp_bit.push_back(bit'((v >> i) & 1));
  endtask

  task automatic send(input logic [W-1:0] w, output int acc, output bit ok);
    ok       = 1'b0;
    acc      = -1;
    valid_in = 1'b1;
    data_in  = w;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_100KHz);
      if (ready_out === 1'b1) begin
        acc = cyc;
        tick();
        ok = 1'b1;
        break;
      end
    end
    valid_in = 1'b0;
    data_in  = W'($urandom);
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_100KHz);
      if (busy_out === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valid_in  = 1'($urandom);
      data_in   = W'($urandom);
      status_in = 1'($urandom);
      tick();
      checks++;
      if ({ready_out, write_out, data_out, busy_out} !== 4'b1000)
        $display("FAIL reset_outputs: ready/write/data/busy=%b required 1000",
                 {ready_out, write_out, data_out, busy_out});
      if ({ready_out, write_out, data_out, busy_out} !== 4'b1000) errors++;
    end
    valid_in  = 1'b0;
    status_in = 1'b0;
    @(negedge clk_100KHz);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int acc;
    bit ok;
    bit ok2;
    logic [W-1:0] rx;
    clear_mon();
    model_word(8'hAD);
    send(8'hAD, acc, ok);
    wait_idle(ok2);
    checks++;
    if (!(ok && ok2)) begin
      errors++;
      $display("FAIL single_timeout: accept=%0d idle=%0d required 1 1", ok, ok2);
    end
    checks++;
    if (strb_bit.size() !== W) begin
      errors++;
      $display("FAIL single_count: %0d strobes required %0d", strb_bit.size(), W);
    end else begin
      rx = '0;
      for (int i = 0; i < W; i++) begin
        rx = {rx[W-2:0], strb_bit[i]};
        checks++;
        if (strb_bit[i] !== exp_bit[i]) begin
          errors++;
          $display("FAIL single_bit%0d: got %0d required %0d", i, strb_bit[i], exp_bit[i]);
        end
        if (i > 0) begin
          checks++;
          if (strb_cyc[i] - strb_cyc[i-1] !== STEP) begin
            errors++;
            $display("FAIL single_spacing%0d: got %0d required %0d", i,
                     strb_cyc[i] - strb_cyc[i-1], STEP);
          end
        end
      end
      checks++;
      if (strb_cyc[0] !== acc + 1) begin
        errors++;
        $display("FAIL single_latency: first strobe cycle %0d required %0d", strb_cyc[0], acc + 1);
      end
      checks++;
      if (rx !== 8'hAD) begin
        errors++;
        $display("FAIL single_loopback: got %h required ad", rx);
      end
    end
  endtask

  task automatic test_status_hold();
    int acc;
    int fall;
    bit ok;
    bit ok2;
    clear_mon();
    model_word(8'h3C);
    status_in = 1'b1;
    send(8'h3C, acc, ok);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (strb_bit.size() !== 0 || busy_out !== 1'b1) begin
        errors++;
        $display("FAIL status_hold: strobes=%0d busy=%b required 0 1", strb_bit.size(), busy_out);
      end
    end
    status_in = 1'b0;
    fall = cyc;
    wait_idle(ok2);
    checks++;
    if (!(ok && ok2) || strb_bit.size() !== W) begin
      errors++;
      $display("FAIL status_count: ok=%0d%0d strobes=%0d required 11 %0d", ok, ok2, strb_bit.size(), W);
    end else begin
      checks++;
      if (strb_cyc[0] !== fall + 1) begin
        errors++;
        $display("FAIL status_latency: first strobe cycle %0d required %0d", strb_cyc[0], fall + 1);
      end
      for (int i = 0; i < W; i++) begin
        checks++;
        if (strb_bit[i] !== exp_bit[i]) begin
          errors++;
          $display("FAIL status_bit%0d: got %0d required %0d", i, strb_bit[i], exp_bit[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc0;
    int accepted;
    bit ok2;
    clear_mon();
    model_word(8'hFF);
    model_word(8'h00);
    acc0      = -1;
    accepted  = 0;
    valid_in  = 1'b1;
    data_in   = 8'hFF;
    for (int i = 0; i < 200 && accepted < 2; i++) begin
      @(negedge clk_100KHz);
      if (ready_out === 1'b1) begin
        if (accepted == 0) acc0 = cyc;
        tick();
        accepted++;
        data_in = 8'h00;
      end
    end
    valid_in = 1'b0;
    wait_idle(ok2);
    checks++;
    if (accepted != 2 || !ok2 || strb_bit.size() !== 2 * W) begin
      errors++;
      $display("FAIL b2b_count: accepted=%0d idle=%0d strobes=%0d required 2 1 %0d",
               accepted, ok2, strb_bit.size(), 2 * W);
    end else begin
      checks++;
      if (strb_cyc[0] !== acc0 + 1) begin
        errors++;
        $display("FAIL b2b_latency: first strobe cycle %0d required %0d", strb_cyc[0], acc0 + 1);
      end
      for (int i = 0; i < 2 * W; i++) begin
        checks++;
        if (strb_bit[i] !== exp_bit[i]) begin
          errors++;
          $display("FAIL b2b_bit%0d: got %0d required %0d", i, strb_bit[i], exp_bit[i]);
        end
        if (i > 0) begin
          checks++;
          if (strb_cyc[i] - strb_cyc[i-1] !== STEP) begin
            errors++;
            $display("FAIL b2b_spacing%0d: got %0d required %0d", i,
                     strb_cyc[i] - strb_cyc[i-1], STEP);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    bit ok;
    bit ok2;
    bit seen;
    clear_mon();
    model_word(8'h5A);
    send(8'h5A, acc, ok);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_100KHz);
      if (strb_bit.size() >= 3) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge clk_100KHz);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (!(ok && seen) || {ready_out, write_out, data_out, busy_out} !== 4'b1000) begin
      errors++;
      $display("FAIL midreset_outputs: ok=%0d%0d ready/write/data/busy=%b required 11 1000",
               ok, seen, {ready_out, write_out, data_out, busy_out});
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (strb_bit.size() !== 3) begin
      errors++;
      $display("FAIL midreset_abandon: %0d strobes required 3", strb_bit.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (strb_bit[i] !== exp_bit[i]) begin
          errors++;
          $display("FAIL midreset_bit%0d: got %0d required %0d", i, strb_bit[i], exp_bit[i]);
        end
      end
    end
    @(negedge clk_100KHz);
    reset = 1'b1;
    tick();
    clear_mon();
    model_word(8'h81);
    send(8'h81, acc, ok);
    wait_idle(ok2);
    checks++;
    if (!(ok && ok2) || strb_bit.size() !== W) begin
      errors++;
      $display("FAIL after_reset_count: ok=%0d%0d strobes=%0d required 11 %0d", ok, ok2, strb_bit.size(), W);
    end else begin
      for (int i = 0; i < W; i++) begin
        checks++;
        if (strb_bit[i] !== exp_bit[i]) begin
          errors++;
          $display("FAIL after_reset_bit%0d: got %0d required %0d", i, strb_bit[i], exp_bit[i]);
        end
      end
    end
  endtask

  task automatic test_buffer();
    int acc;
    bit ok;
    bit ok2;
    bit seen;
    logic [W-1:0] a;
    logic [W-1:0] c;
    a = W'($urandom);
    c = W'($urandom);
    clear_mon();
    model_word(a);
    send(a, acc, ok);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (strb_bit.size() >= 2) begin
        seen = 1'b1;
        break;
      end
    end
    valid_in = 1'b1;
    data_in  = 8'h12;
`ifdef SERIALIZADOR_BUF_EN
    model_word(8'h12);
    model_word(c);
    checks++;
    if (!(ok && seen) || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL buf_accept_mid: ok=%0d%0d ready=%b required 11 1", ok, seen, ready_out);
    end
    tick();
    data_in = c;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ready_out === 1'b1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!seen || strb_bit.size() !== W) begin
      errors++;
      $display("FAIL buf_refuse_third: ready seen=%0d after %0d strobes required 1 after %0d",
               seen, strb_bit.size(), W);
    end
    tick();
    valid_in = 1'b0;
    wait_idle(ok2);
    checks++;
    if (!ok2 || strb_bit.size() !== 3 * W) begin
      errors++;
      $display("FAIL buf_count: idle=%0d strobes=%0d required 1 %0d", ok2, strb_bit.size(), 3 * W);
    end else begin
      for (int i = 0; i < 3 * W; i++) begin
        checks++;
        if (strb_bit[i] !== exp_bit[i]) begin
          errors++;
          $display("FAIL buf_bit%0d: got %0d required %0d", i, strb_bit[i], exp_bit[i]);
        end
        if (i > 0) begin
          checks++;
          if (strb_cyc[i] - strb_cyc[i-1] !== STEP) begin
            errors++;
            $display("FAIL buf_spacing%0d: got %0d required %0d", i,
                     strb_cyc[i] - strb_cyc[i-1], STEP);
          end
        end
      end
    end
`else
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (!(ok && seen) || ready_out !== 1'b0) begin
        errors++;
        $display("FAIL nobuf_refuse: ok=%0d%0d ready=%b required 11 0", ok, seen, ready_out);
      end
      tick();
    end
    valid_in = 1'b0;
    wait_idle(ok2);
    checks++;
    if (!ok2 || strb_bit.size() !== W) begin
      errors++;
      $display("FAIL nobuf_ignored: idle=%0d strobes=%0d required 1 %0d", ok2, strb_bit.size(), W);
    end else begin
      for (int i = 0; i < W; i++) begin
        checks++;
        if (strb_bit[i] !== exp_bit[i]) begin
          errors++;
          $display("FAIL nobuf_bit%0d: got %0d required %0d", i, strb_bit[i], exp_bit[i]);
        end
      end
    end
`endif
  endtask

  task automatic test_random();
    int acc;
    int fall;
    int hold;
    bit ok;
    bit ok2;
    logic [W-1:0] w;
    for (int n = 0; n < 6; n++) begin
      w    = W'($urandom);
      hold = $urandom_range(0, 3);
      clear_mon();
      model_word(w);
      status_in = (hold != 0);
      send(w, acc, ok);
      for (int i = 0; i < hold; i++) tick();
      status_in = 1'b0;
      fall = cyc;
      wait_idle(ok2);
      checks++;
      if (!(ok && ok2) || strb_bit.size() !== W) begin
        errors++;
        $display("FAIL rand%0d_count: ok=%0d%0d strobes=%0d required 11 %0d", n, ok, ok2, strb_bit.size(), W);
      end else begin
        checks++;
        if (strb_cyc[0] !== ((hold != 0) ? fall + 1 : acc + 1)) begin
          errors++;
          $display("FAIL rand%0d_latency: first strobe cycle %0d required %0d", n, strb_cyc[0],
                   (hold != 0) ? fall + 1 : acc + 1);
        end
        for (int i = 0; i < W; i++) begin
          checks++;
          if (strb_bit[i] !== exp_bit[i]) begin
            errors++;
            $display("FAIL rand%0d_bit%0d: word %h got %0d required %0d", n, i, w, strb_bit[i], exp_bit[i]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_status_hold();
    test_back_to_back();
    test_reset_mid();
    test_buffer();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
